neck_detect_pipe: RTL and testbench



---
 rtl/neck_detect_pipe_pkg.sv | 30 +++
 rtl/neck_detect_pipe_dif_chain.sv | 65 ++++++
 rtl/neck_detect_pipe.sv | 129 ++++++++++++
 tb/tb_neck_detect_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/neck_detect_pipe_pkg.sv
// Shared types, constants and saturation helper for the necking detector.
package neck_detect_pipe_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CUT     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int          DEF_TH_D1          = 40;
  localparam int          DEF_TH_DN          = 5;
  localparam int unsigned DEF_N_CONFIRM      = 3;
  localparam int unsigned DEF_OFF_CYCLES     = 20000;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 50000;

  localparam int unsigned SAT_W = 32;

  // Clamp a full-precision signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_to_w(input logic signed [SAT_W-1:0] x,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/neck_detect_pipe_dif_chain.sv
// Decimator, sample history and saturating difference stages with warm-up gating.
module neck_detect_pipe_dif_chain
  import neck_detect_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 13,
  parameter int unsigned DIF_ORDER  = 3,
  parameter int unsigned SAMPLE_DIV = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              dif_valid,
  output logic [DATA_W-1:0] dif_d1,
  output logic [DATA_W-1:0] dif_dn
);

  localparam int          K      = int'(DIF_ORDER);
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WARM_W = $clog2(DIF_ORDER + 1);

  logic [DIV_W-1:0]         div_cnt;
  logic [WARM_W-1:0]        warm_cnt;
  logic signed [DATA_W-1:0] hist [K];
  logic signed [DATA_W-1:0] lvl  [K+1][K+1];
  logic                     accept_c;

  assign accept_c = in_valid && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  // lvl[j][i]: j-th difference ending at sample i (i=0 is the incoming sample).
  always_comb begin
    for (int j = 0; j <= K; j++) begin
      for (int i = 0; i <= K; i++) lvl[j][i] = '0;
    end
    lvl[0][0] = $signed(in_data);
    for (int i = 1; i <= K; i++) lvl[0][i] = hist[i-1];
    for (int j = 1; j <= K; j++) begin
      for (int i = 0; i + j <= K; i++) begin
        lvl[j][i] = DATA_W'(sat_to_w(SAT_W'(lvl[j-1][i]) - SAT_W'(lvl[j-1][i+1]), DATA_W));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      warm_cnt  <= '0;
      dif_valid <= 1'b0;
      dif_d1    <= '0;
      dif_dn    <= '0;
      for (int i = 0; i < K; i++) hist[i] <= '0;
    end else begin
      dif_valid <= accept_c && (warm_cnt == WARM_W'(K));
      if (in_valid) div_cnt <= accept_c ? '0 : div_cnt + DIV_W'(1);
      if (accept_c) begin
        hist[0] <= $signed(in_data);
        for (int i = 1; i < K; i++) hist[i] <= hist[i-1];
        dif_d1 <= lvl[1][0];
        dif_dn <= lvl[K][0];
        if (warm_cnt != WARM_W'(K)) warm_cnt <= warm_cnt + WARM_W'(1);
      end
    end
  end

endmodule

// File: rtl/neck_detect_pipe.sv
// Necking detector: difference chain, N-sample confirmation and power cut / hold-off timing.
module neck_detect_pipe
  import neck_detect_pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 13,
  parameter int unsigned DIF_ORDER      = 3,
  parameter int unsigned SAMPLE_DIV     = 10,
  parameter int          TH_D1          = DEF_TH_D1,
  parameter int          TH_DN          = DEF_TH_DN,
  parameter int unsigned N_CONFIRM      = DEF_N_CONFIRM,
  parameter int unsigned OFF_CYCLES     = DEF_OFF_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ctrl_switch,
  output logic              dif_valid,
  output logic [DATA_W-1:0] dif_d1,
  output logic [DATA_W-1:0] dif_dn,
  output logic              neck_pulse,
  output logic              power_switch,
  output logic              busy
);

  localparam int unsigned CNT_W   = $clog2(N_CONFIRM + 1);
  localparam int unsigned TMR_MAX = (OFF_CYCLES > HOLDOFF_CYCLES) ? OFF_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic signed [DATA_W-1:0] TH_D1_W = DATA_W'(TH_D1);
  localparam logic signed [DATA_W-1:0] TH_DN_W = DATA_W'(TH_DN);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic             pulse_next, power_next, busy_next;
  logic             qualify_c;

  neck_detect_pipe_dif_chain #(
    .DATA_W     (DATA_W),
    .DIF_ORDER  (DIF_ORDER),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_dif_chain (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .dif_valid (dif_valid),
    .dif_d1    (dif_d1),
    .dif_dn    (dif_dn)
  );

  assign qualify_c = ($signed(dif_d1) >= TH_D1_W) &&
                     ((DIF_ORDER == 1) || ($signed(dif_dn) >= TH_DN_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARMED;
      cnt          <= '0;
      tmr          <= '0;
      neck_pulse   <= 1'b0;
      power_switch <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      tmr          <= tmr_next;
      neck_pulse   <= pulse_next;
      power_switch <= power_next;
      busy         <= busy_next;
    end
  end

  // Manual override (ctrl_switch=0) dominates every state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tmr_next   = tmr;
    pulse_next = 1'b0;
    power_next = power_switch;
    busy_next  = busy;
    if (!ctrl_switch) begin
      state_next = ARMED;
      cnt_next   = '0;
      tmr_next   = '0;
      power_next = 1'b1;
      busy_next  = 1'b0;
    end else begin
      unique case (state)
        ARMED: begin
          if (dif_valid) begin
            if (qualify_c) cnt_next = (cnt == CNT_W'(N_CONFIRM)) ? cnt : cnt + CNT_W'(1);
            else           cnt_next = '0;
          end
          if (cnt_next == CNT_W'(N_CONFIRM)) begin
            state_next = CUT;
            cnt_next   = '0;
            tmr_next   = '0;
            pulse_next = 1'b1;
            power_next = 1'b0;
            busy_next  = 1'b1;
          end
        end
        CUT: begin
          cnt_next = '0;
          if (tmr == TMR_W'(OFF_CYCLES - 1)) begin
            tmr_next   = '0;
            power_next = 1'b1;
            state_next = HOLDOFF;
          end else begin
            tmr_next = tmr + TMR_W'(1);
          end
        end
        HOLDOFF: begin
          cnt_next = '0;
          if (tmr == TMR_W'(HOLDOFF_CYCLES - 1)) begin
            tmr_next   = '0;
            busy_next  = 1'b0;
            state_next = ARMED;
          end else begin
            tmr_next = tmr + TMR_W'(1);
          end
        end
        default: state_next = ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_neck_detect_pipe.sv
// Directed bench for neck_detect_pipe: warm-up, decimation, saturation, detection timing, override, reset.
module tb_neck_detect_pipe;

  localparam int DATA_W = 13;
  localparam int OFF    = 20;
  localparam int HOLD   = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              ctrl_switch;

  logic              dif_valid, neck_pulse, power_switch, busy;
  logic [DATA_W-1:0] dif_d1, dif_dn;
  logic              d3_valid, d3_pulse, d3_power, d3_busy;
  logic [DATA_W-1:0] d3_d1, d3_dn;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neck_detect_pipe #(
    .DATA_W(DATA_W), .DIF_ORDER(2), .SAMPLE_DIV(1), .TH_D1(40), .TH_DN(5),
    .N_CONFIRM(3), .OFF_CYCLES(OFF), .HOLDOFF_CYCLES(HOLD)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ctrl_switch(ctrl_switch),
    .dif_valid(dif_valid), .dif_d1(dif_d1), .dif_dn(dif_dn),
    .neck_pulse(neck_pulse), .power_switch(power_switch), .busy(busy)
  );

  neck_detect_pipe #(
    .DATA_W(DATA_W), .DIF_ORDER(3), .SAMPLE_DIV(2), .TH_D1(40), .TH_DN(5),
    .N_CONFIRM(3), .OFF_CYCLES(5), .HOLDOFF_CYCLES(5)
  ) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ctrl_switch(ctrl_switch),
    .dif_valid(d3_valid), .dif_d1(d3_d1), .dif_dn(d3_dn),
    .neck_pulse(d3_pulse), .power_switch(d3_power), .busy(d3_busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the accept's outputs visible.
  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input int v, input int vld, input int d1, input int dn);
    send(v);
    check($sformatf("%s.valid", tag), int'(dif_valid), vld);
    if (vld != 0) begin
      check($sformatf("%s.d1", tag), int'($signed(dif_d1)), d1);
      check($sformatf("%s.dn", tag), int'($signed(dif_dn)), dn);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, offs, busys;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; ctrl_switch = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst.power", int'(power_switch), 1);
    check("rst.pulse", int'(neck_pulse), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.valid", int'(dif_valid), 0);
    check("rst.d1", int'(dif_d1), 0);
    check("rst.dn", int'(dif_dn), 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp: order-2 warm-up on the 3rd sample; order-3 / div-2 instance on the 8th input.
    send_chk("ramp0", 0, 0, 0, 0);
    send_chk("ramp1", 10, 0, 0, 0);
    for (int k = 2; k < 8; k++) begin
      send_chk($sformatf("ramp%0d", k), 10 * k, 1, 10, 0);
      if (k == 5) check("d3.warm5", int'(d3_valid), 0);
      if (k == 6) check("d3.warm6", int'(d3_valid), 0);
    end
    check("d3.valid", int'(d3_valid), 1);
    check("d3.d1", int'($signed(d3_d1)), 20);
    check("d3.dn", int'($signed(d3_dn)), 0);
    @(negedge clk);
    check("idle.valid", int'(dif_valid), 0);
    check("ramp.pulse", int'(neck_pulse), 0);
    check("ramp.power", int'(power_switch), 1);

    // Saturation of each stage before feeding the next.
    send_chk("sat0", 0, 1, -70, -80);
    send_chk("sat1", -4096, 1, -4096, -4026);
    send_chk("sat2", 4095, 1, 4095, 4095);
    send_chk("sat3", 4095, 1, 0, -4095);
    send_chk("sat4", -4096, 1, -4096, -4096);

    // Quadratic rise: d1 = 45, 55, 65 with d2 = 10 confirms on the third.
    send_chk("q0", 0, 1, 4095, 4095);
    send_chk("q5", 5, 1, 5, -4090);
    send_chk("q20", 20, 1, 15, 10);
    send_chk("q45", 45, 1, 25, 10);
    send_chk("q80", 80, 1, 35, 10);
    send_chk("q125", 125, 1, 45, 10);
    send_chk("q180", 180, 1, 55, 10);
    send_chk("q245", 245, 1, 65, 10);
    check("q245.pre", int'(neck_pulse), 0);
    @(negedge clk);
    check("det1.pulse", int'(neck_pulse), 1);
    check("det1.power", int'(power_switch), 0);
    check("det1.busy", int'(busy), 1);
    pulses = 0; offs = 0; busys = 0;
    for (int c = 0; c < 300 && busy; c++) begin
      pulses += int'(neck_pulse);
      offs   += int'(!power_switch);
      busys  += int'(busy);
      @(negedge clk);
    end
    check("det1.busy_end", int'(busy), 0);
    check("det1.pulses", pulses, 1);
    check("det1.off_cycles", offs, OFF);
    check("det1.busy_cycles", busys, OFF + HOLD);

    // Second detection, then qualifies during hold-off are ignored.
    send(320); send(405); send(500);
    check("det2.pre", int'(neck_pulse), 0);
    @(negedge clk);
    check("det2.pulse", int'(neck_pulse), 1);
    repeat (22) @(negedge clk);
    check("hold.power", int'(power_switch), 1);
    check("hold.busy", int'(busy), 1);
    pulses = 0;
    send_chk("hold605", 605, 1, 105, 10); pulses += int'(neck_pulse);
    send(720); pulses += int'(neck_pulse);
    send(845); pulses += int'(neck_pulse);
    for (int c = 0; c < 100 && busy; c++) begin
      @(negedge clk);
      pulses += int'(neck_pulse);
    end
    check("hold.busy_end", int'(busy), 0);
    check("hold.pulses", pulses, 0);
    send(980);  check("re1.pulse", int'(neck_pulse), 0);
    send(1125); check("re2.pulse", int'(neck_pulse), 0);
    send(1280); check("re3.pulse", int'(neck_pulse), 0);
    @(negedge clk);
    check("det3.pulse", int'(neck_pulse), 1);

    // Manual override during CUT.
    repeat (3) @(negedge clk);
    ctrl_switch = 1'b0;
    @(negedge clk);
    check("ovr.power", int'(power_switch), 1);
    check("ovr.busy", int'(busy), 0);
    pulses = 0;
    send_chk("ovr1445", 1445, 1, 165, 10); pulses += int'(neck_pulse);
    send_chk("ovr1620", 1620, 1, 175, 10); pulses += int'(neck_pulse);
    send_chk("ovr1805", 1805, 1, 185, 10); pulses += int'(neck_pulse);
    @(negedge clk); pulses += int'(neck_pulse);
    @(negedge clk); pulses += int'(neck_pulse);
    check("ovr.pulses", pulses, 0);
    check("ovr.power2", int'(power_switch), 1);
    ctrl_switch = 1'b1;
    send(2000); check("ret1.pulse", int'(neck_pulse), 0);
    send(2205); check("ret2.pulse", int'(neck_pulse), 0);
    send(2420); check("ret3.pulse", int'(neck_pulse), 0);
    @(negedge clk);
    check("det4.pulse", int'(neck_pulse), 1);
    check("det4.power", int'(power_switch), 0);

    // Asynchronous reset in CUT restores power and forces a fresh warm-up.
    repeat (2) @(negedge clk);
    check("cut.power", int'(power_switch), 0);
    #2 rst = 1'b1;
    #1;
    check("arst.power", int'(power_switch), 1);
    check("arst.busy", int'(busy), 0);
    check("arst.d1", int'(dif_d1), 0);
    @(negedge clk);
    rst = 1'b0;
    send_chk("rw50", 50, 0, 0, 0);
    send_chk("rw60", 60, 0, 0, 0);
    send_chk("rw70", 70, 1, 10, 0);
    check("rw.power", int'(power_switch), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
